// File: rtl/shift_chain_arbiter_if.sv
// Bus bundle for shift_chain_arbiter: requester words and requests in; grant, done and serial
// stream out. The master modport is the requester side and the slave modport is the arbiter side.
interface shift_chain_arbiter_if #(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 8
);
    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] data_in;
    logic [N-1:0]       grant;
    logic               busy;
    logic               serial_out;
    logic               frame;
    logic [N-1:0]       done;

    modport master (
        output req,
        output data_in,
        input  grant,
        input  busy,
        input  serial_out,
        input  frame,
        input  done
    );

    modport slave (
        input  req,
        input  data_in,
        output grant,
        output busy,
        output serial_out,
        output frame,
        output done
    );
endinterface

// File: rtl/shift_chain_arbiter.sv
// Round-robin arbiter that shares one MSB-first serial channel between N requesters.
// Define SHIFT_ARB_PARITY_EN to append an even-parity bit to every frame.
module shift_chain_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 8
) (
    input logic                  clk,
    input logic                  reset,
    shift_chain_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
`ifdef SHIFT_ARB_PARITY_EN
    localparam int unsigned LAST_BIT = WIDTH;
`else
    localparam int unsigned LAST_BIT = WIDTH - 1;
`endif

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   shreg_q;
    logic [N-1:0]       grant_q;
    logic [N-1:0]       done_q;
    logic               busy_q;
    logic               serial_q;
    logic               frame_q;
`ifdef SHIFT_ARB_PARITY_EN
    logic               parity_q;
`endif

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand_idx;
    logic [WIDTH-1:0]   pick_word;
    logic [IDX_W-1:0]   ptr_next;
    int unsigned        cand;

    // First requester at or above the pointer, wrapping modulo N.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IDX_W'(cand);
            if (!pick_valid && bus.req[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    assign pick_word = bus.data_in[pick_idx*WIDTH +: WIDTH];
    assign ptr_next  = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            shreg_q  <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            serial_q <= 1'b0;
            frame_q  <= 1'b0;
`ifdef SHIFT_ARB_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= '0;
                    if (pick_valid) begin
                        grant_q  <= N'(1) << pick_idx;
                        idx_q    <= pick_idx;
                        // MSB goes straight to the output; the rest waits in the shifter.
                        serial_q <= pick_word[WIDTH-1];
                        shreg_q  <= pick_word << 1;
                        frame_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= StShift;
`ifdef SHIFT_ARB_PARITY_EN
                        parity_q <= ^pick_word;
`endif
                    end
                end
                StShift: begin
                    if (cnt_q == CNT_W'(LAST_BIT)) begin
                        frame_q  <= 1'b0;
                        serial_q <= 1'b0;
                        done_q   <= grant_q;
                        state_q  <= StDone;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                        shreg_q <= shreg_q << 1;
`ifdef SHIFT_ARB_PARITY_EN
                        serial_q <= (cnt_q == CNT_W'(WIDTH - 1)) ? parity_q : shreg_q[WIDTH-1];
`else
                        serial_q <= shreg_q[WIDTH-1];
`endif
                    end
                end
                StDone: begin
                    done_q  <= '0;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    ptr_q   <= ptr_next;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.grant      = grant_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;
    assign bus.serial_out = serial_q;
    assign bus.frame      = frame_q;
endmodule

// File: tb/tb_shift_chain_arbiter.sv
// Self-checking bench for shift_chain_arbiter: table-driven single transfers, round-robin,
// mid-transfer changes and reset abort, with a scoreboard of expected frames.
module tb_shift_chain_arbiter;
    localparam int unsigned N     = 4;
    localparam int unsigned WIDTH = 8;
`ifdef SHIFT_ARB_PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif

    typedef struct {
        int unsigned      idx;
        logic [WIDTH-1:0] word;
    } exp_t;

    typedef struct {
        logic [N-1:0]       req;
        logic [N*WIDTH-1:0] data;
        int unsigned        idx;
    } vec_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    exp_t exp_q[$];
    exp_t e;
    vec_t vecs[10];

    logic [WIDTH:0] acc;
    int             nbits;
    logic           prev_frame;

    shift_chain_arbiter_if #(.N(N), .WIDTH(WIDTH)) bus ();

    shift_chain_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endfunction

    function automatic logic [WIDTH-1:0] word_of(input logic [N*WIDTH-1:0] d,
                                                 input int unsigned idx);
        return d[idx*WIDTH +: WIDTH];
    endfunction

    function automatic logic [WIDTH:0] want_bits(input logic [WIDTH-1:0] w);
`ifdef SHIFT_ARB_PARITY_EN
        return {w, ^w};
`else
        return {1'b0, w};
`endif
    endfunction

    // Collects each frame and checks it against the scoreboard when done pulses.
    always @(negedge clk) begin
        if (!reset) begin
            prev_frame = 1'b0;
            nbits      = 0;
            acc        = '0;
        end else begin
            if (bus.frame && !prev_frame) begin
                acc   = '0;
                nbits = 0;
            end
            if (bus.frame) begin
                acc = {acc[WIDTH-1:0], bus.serial_out};
                nbits++;
            end else begin
                check("serial_idle", 64'(bus.serial_out), 64'd0);
            end
            if (prev_frame && !bus.frame) begin
                check("done_after_last_bit", 64'(|bus.done), 64'd1);
            end
            if (bus.done != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'(bus.done), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_onehot", 64'(bus.done), 64'(1) << e.idx);
                    check("grant_at_done", 64'(bus.grant), 64'(1) << e.idx);
                    check("busy_at_done", 64'(bus.busy), 64'd1);
                    check("frame_len", 64'(nbits), 64'(NB));
                    check("frame_bits", 64'(acc), 64'(want_bits(e.word)));
                end
            end
            prev_frame = bus.frame;
        end
    end

    task automatic do_xfer(input logic [N-1:0] r, input logic [N*WIDTH-1:0] d,
                           input int unsigned idx);
        logic [WIDTH-1:0] w;
        int c;
        w           = word_of(d, idx);
        bus.req     = r;
        bus.data_in = d;
        exp_q.push_back('{idx, w});
        @(negedge clk);
        check("grant", 64'(bus.grant), 64'(1) << idx);
        check("first_frame", 64'(bus.frame), 64'd1);
        check("first_busy", 64'(bus.busy), 64'd1);
        check("first_bit", 64'(bus.serial_out), 64'(w[WIDTH-1]));
        c = 1;
        while (bus.done == '0 && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("done_latency", 64'(c), 64'(NB + 1));
        bus.req = '0;
        @(negedge clk);
        check("idle_grant", 64'(bus.grant), 64'd0);
        check("idle_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        int c;
        logic [N*WIDTH-1:0] d;

        vecs[0] = '{4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00}, 2};
        vecs[1] = '{4'b1001, {8'h07, 8'h00, 8'h00, 8'hF0}, 3};
        vecs[2] = '{4'b1001, {8'h81, 8'h00, 8'h00, 8'h03}, 0};
        vecs[3] = '{4'b0110, {8'h00, 8'h55, 8'hC3, 8'h00}, 1};
        vecs[4] = '{4'b0001, {8'h00, 8'h00, 8'h00, 8'hFF}, 0};
        vecs[5] = '{4'b1100, {8'h12, 8'h80, 8'h00, 8'h00}, 2};
        vecs[6] = '{4'b0011, {8'h00, 8'h00, 8'h6E, 8'h01}, 0};
        vecs[7] = '{4'b1000, {8'h9B, 8'h00, 8'h00, 8'h00}, 3};
        vecs[8] = '{4'b1001, {8'h40, 8'h00, 8'h00, 8'h2D}, 0};
        vecs[9] = '{4'b1001, {8'hE7, 8'h00, 8'h00, 8'h18}, 3};

        reset       = 1'b0;
        bus.req     = '1;
        bus.data_in = {8'h11, 8'h22, 8'h33, 8'h5A};
        repeat (3) @(negedge clk);
        check("rst_grant", 64'(bus.grant), 64'd0);
        check("rst_frame", 64'(bus.frame), 64'd0);
        check("rst_serial", 64'(bus.serial_out), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        reset = 1'b1;
        do_xfer('1, {8'h11, 8'h22, 8'h33, 8'h5A}, 0);

        // Pointer is now 1; table expectations follow from that.
        for (int i = 0; i < 10; i++) begin
            do_xfer(vecs[i].req, vecs[i].data, vecs[i].idx);
        end

        // Round-robin with all requesting; each drops on done and returns in the idle cycle.
        d           = {8'hD4, 8'h2B, 8'h96, 8'h69};
        bus.data_in = d;
        bus.req     = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            exp_q.push_back('{t % 4, word_of(d, t % 4)});
        end
        for (int t = 0; t < 5; t++) begin
            c = 0;
            do begin
                @(negedge clk);
                c++;
            end while (bus.done == '0 && c < 40);
            check("rr_done_seen", 64'(|bus.done), 64'd1);
            if (t == 4) begin
                bus.req = '0;
            end else begin
                bus.req[2'(t % 4)] = 1'b0;
                @(negedge clk);
                check("rr_gap_idle", 64'(bus.frame), 64'd0);
                bus.req[2'(t % 4)] = 1'b1;
                @(negedge clk);
                check("rr_gap_end", 64'(bus.frame), 64'd1);
            end
        end
        repeat (2) @(negedge clk);

        // Requester 1 drops req and changes its word mid-frame.
        bus.data_in = {8'h00, 8'h00, 8'h3C, 8'h00};
        bus.req     = 4'b0010;
        exp_q.push_back('{1, 8'h3C});
        repeat (4) @(negedge clk);
        bus.req     = '0;
        bus.data_in = {8'h00, 8'h00, 8'hFF, 8'h00};
        c = 0;
        while (bus.done == '0 && c < 40) begin
            @(negedge clk);
            c++;
        end
        check("mid_done_seen", 64'(|bus.done), 64'd1);
        repeat (2) @(negedge clk);

        // Reset during the fourth bit of a transfer to requester 2.
        d           = {8'h00, 8'hC6, 8'h00, 8'h77};
        bus.data_in = d;
        bus.req     = 4'b0101;
        @(negedge clk);
        check("abort_grant", 64'(bus.grant), 64'b0100);
        repeat (3) @(negedge clk);
        check("abort_mid_frame", 64'(bus.frame), 64'd1);
        #1 reset = 1'b0;
        #1;
        check("abort_grant_clr", 64'(bus.grant), 64'd0);
        check("abort_frame_clr", 64'(bus.frame), 64'd0);
        check("abort_serial_clr", 64'(bus.serial_out), 64'd0);
        check("abort_busy_clr", 64'(bus.busy), 64'd0);
        @(negedge clk);
        check("abort_no_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        do_xfer(4'b0101, d, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
